// File: rtl/ram_pass_controller.sv
// ram_pass_controller
// Sequences one read/write pass over a pair of dual-port RAMs. Port A of both
// RAMs is read at read_address_o; one cycle later (the RAM read latency) the
// result is written back through port B at write_address_o, with per-RAM
// write enables taken from the mask latched at start.
//
// Ports
//   CLOCK_50_I       system clock, rising edge
//   resetn           asynchronous active-low reset
//   start_i          request a pass (sampled only in S_IDLE)
//   abort_i          end the active pass early
//   base_addr_i      first address of the pass
//   last_addr_i      final address of the pass (may wrap below base)
//   we_mask_i        write enable mask, bit0 RAM0 (sum), bit1 RAM1 (difference)
//   read_address_o   port A address of both RAMs
//   write_address_o  port B address of both RAMs
//   write_enable_o   port B write enables, RAM1:RAM0
//   busy_o           pass in progress
//   done_o           one-cycle pulse in the first idle cycle after a pass
//   aborted_o        qualifies done_o; held until the next accepted start
//   pass_count_o     number of completed, non-aborted passes (wraps)
module ram_pass_controller #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              CLOCK_50_I,
   input  logic              resetn,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W-1:0] last_addr_i,
   input  logic [1:0]        we_mask_i,
   output logic [ADDR_W-1:0] read_address_o,
   output logic [ADDR_W-1:0] write_address_o,
   output logic [1:0]        write_enable_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              aborted_o,
   output logic [CNT_W-1:0]  pass_count_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ_WRITE,
      S_LAST_WRITE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [1:0]        mask_q, mask_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [1:0]        we_q, we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      mask_d    = mask_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      we_d      = we_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      aborted_d = aborted_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               last_d    = last_addr_i;
               mask_d    = we_mask_i;
               rd_addr_d = base_addr_i;
               busy_d    = 1'b1;
               aborted_d = 1'b0;
               state_d   = S_READ_WRITE;
            end
         end

         S_READ_WRITE: begin
            // Write back the address read one cycle ago; address wraps mod 2^ADDR_W.
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            wr_addr_d = rd_addr_q;
            we_d      = mask_q;
            if (abort_i) begin
               aborted_d = 1'b1;
               state_d   = S_LAST_WRITE;
            end else if (rd_addr_q == last_q) begin
               state_d   = S_LAST_WRITE;
            end
         end

         S_LAST_WRITE: begin
            // Final scheduled write is on the bus this cycle; close the pass.
            we_d      = 2'b00;
            rd_addr_d = '0;
            wr_addr_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            if (!aborted_q) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         last_q    <= '0;
         mask_q    <= 2'b00;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         we_q      <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         mask_q    <= mask_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         we_q      <= we_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         cnt_q     <= cnt_d;
      end
   end

   assign read_address_o  = rd_addr_q;
   assign write_address_o = wr_addr_q;
   assign write_enable_o  = we_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign aborted_o       = aborted_q;
   assign pass_count_o    = cnt_q;

endmodule

// File: tb/tb_ram_pass_controller.sv
// Testbench for ram_pass_controller: expected writes and pass completions are
// queued when a pass is launched and checked as the DUT produces them.
module tb_ram_pass_controller;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start_i;
   logic       abort_i;
   logic [8:0] base_addr_i;
   logic [8:0] last_addr_i;
   logic [1:0] we_mask_i;
   logic [8:0] read_address_o;
   logic [8:0] write_address_o;
   logic [1:0] write_enable_o;
   logic       busy_o;
   logic       done_o;
   logic       aborted_o;
   logic [7:0] pass_count_o;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [8:0] addr;
      logic [1:0] we;
   } wr_exp_t;

   typedef struct packed {
      logic       aborted;
      logic [7:0] count;
   } done_exp_t;

   wr_exp_t   wq[$];
   done_exp_t dq[$];
   logic [7:0] cnt_model = 8'd0;

   ram_pass_controller #(.ADDR_W(9), .CNT_W(8)) dut (
      .CLOCK_50_I      (clk),
      .resetn          (resetn),
      .start_i         (start_i),
      .abort_i         (abort_i),
      .base_addr_i     (base_addr_i),
      .last_addr_i     (last_addr_i),
      .we_mask_i       (we_mask_i),
      .read_address_o  (read_address_o),
      .write_address_o (write_address_o),
      .write_enable_o  (write_enable_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .aborted_o       (aborted_o),
      .pass_count_o    (pass_count_o)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: compare each write and each done pulse against the queues
   always @(negedge clk) begin
      if (resetn) begin
         if (write_enable_o != 2'b00) begin
            check("wr_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
               wr_exp_t e;
               e = wq.pop_front();
               check("wr_addr", 32'(write_address_o), 32'(e.addr));
               check("wr_en", 32'(write_enable_o), 32'(e.we));
               check("rd_lead", 32'(read_address_o), 32'(9'(write_address_o + 9'd1)));
            end
         end
         if (done_o) begin
            check("done_expected", 32'(dq.size() != 0), 32'd1);
            if (dq.size() != 0) begin
               done_exp_t d;
               d = dq.pop_front();
               check("aborted", 32'(aborted_o), 32'(d.aborted));
               check("pass_count", 32'(pass_count_o), 32'(d.count));
               check("busy_at_done", 32'(busy_o), 32'd0);
            end
         end
      end
   end

   task automatic check_drained(input string tag);
      @(negedge clk);
      check({tag, "_wq_empty"}, 32'(wq.size()), 32'd0);
      check({tag, "_dq_empty"}, 32'(dq.size()), 32'd0);
   endtask

   // Launch one pass; abort_at>0 raises abort_i in that S_READ_WRITE cycle
   task automatic run_pass(input logic [8:0] base, input logic [8:0] last,
                           input logic [1:0] mask, input int abort_at, input string tag);
      int n, nw, lat;
      bit ab;
      n  = int'(9'(last - base)) + 1;
      ab = (abort_at > 0) && (abort_at <= n);
      nw = ab ? abort_at : n;
      if (mask != 2'b00)
         for (int i = 0; i < nw; i++) wq.push_back('{addr: 9'(base + 9'(i)), we: mask});
      if (!ab) cnt_model = cnt_model + 8'd1;
      dq.push_back('{aborted: ab, count: cnt_model});

      @(negedge clk);
      base_addr_i = base;
      last_addr_i = last;
      we_mask_i   = mask;
      start_i     = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            // Inputs must no longer matter once latched.
            start_i     = 1'b0;
            base_addr_i = 9'($urandom);
            last_addr_i = 9'($urandom);
            we_mask_i   = 2'($urandom);
         end
         abort_i = (abort_at > 0 && lat == abort_at);
      end while (!done_o && lat < 2000);
      abort_i = 1'b0;
      check({tag, "_done_seen"}, 32'(done_o), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(nw + 2));
      check_drained(tag);
      check({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
   endtask

   initial begin
      logic [17:0] hist;
      int cyc;
      resetn = 1'b0;
      start_i = 1'b0;
      abort_i = 1'b0;
      base_addr_i = '0;
      last_addr_i = '0;
      we_mask_i = '0;
      #35;
      check("rst_we", 32'(write_enable_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_cnt", 32'(pass_count_o), 32'd0);
      check("rst_rd", 32'(read_address_o), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", 32'(busy_o), 32'd0);

      run_pass(9'd0, 9'd511, 2'b11, 0, "full");
      run_pass(9'd510, 9'd1, 2'b11, 0, "wrap");
      run_pass(9'd37, 9'd37, 2'b01, 0, "single");
      run_pass(9'd0, 9'd100, 2'b11, 10, "abort");
      run_pass(9'd5, 9'd9, 2'b00, 0, "mask00");
      run_pass(9'd100, 9'd99, 2'b10, 0, "all512");
      run_pass(9'd20, 9'd30, 2'b01, 11, "abort_on_last");

      // Reset in the middle of a pass
      for (int i = 0; i < 512; i++) wq.push_back('{addr: 9'(i), we: 2'b11});
      @(negedge clk);
      base_addr_i = 9'd0;
      last_addr_i = 9'd511;
      we_mask_i   = 2'b11;
      start_i     = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      cyc = 0;
      while (!(write_enable_o != 2'b00 && write_address_o == 9'd200) && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("mid_reached_200", 32'(write_address_o), 32'd200);
      resetn = 1'b0;
      #1;
      check("mid_we", 32'(write_enable_o), 32'd0);
      check("mid_wr", 32'(write_address_o), 32'd0);
      check("mid_rd", 32'(read_address_o), 32'd0);
      check("mid_busy", 32'(busy_o), 32'd0);
      check("mid_done", 32'(done_o), 32'd0);
      check("mid_cnt", 32'(pass_count_o), 32'd0);
      wq.delete();
      cnt_model = 8'd0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", 32'(busy_o | done_o), 32'd0);
      run_pass(9'd0, 9'd3, 2'b11, 0, "after_reset");

      // start_i held through a pass: second pass starts in the done cycle
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 6; i++) wq.push_back('{addr: 9'(i), we: 2'b11});
         cnt_model = cnt_model + 8'd1;
         dq.push_back('{aborted: 1'b0, count: cnt_model});
      end
      @(negedge clk);
      base_addr_i = 9'd0;
      last_addr_i = 9'd5;
      we_mask_i   = 2'b11;
      start_i     = 1'b1;
      hist = '0;
      for (int i = 1; i <= 17; i++) begin
         @(negedge clk);
         hist[i] = (write_enable_o != 2'b00);
         if (i == 9) start_i = 1'b0;
      end
      for (int i = 1; i <= 17; i++)
         check($sformatf("held_we_%0d", i), 32'(hist[i]),
               32'((i >= 2 && i <= 7) || (i >= 10 && i <= 15)));
      check_drained("held");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ram_pass_controller.md
RAM_PASS_CONTROLLER -- requirements
Module: ram_pass_controller

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, giving the RAM address width (512 words).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the completed-pass counter width.
REQ-003 The port CLOCK_50_I SHALL be an input, 1 bit wide: the system clock; all state changes on its rising edge.
REQ-004 The port resetn SHALL be an input, 1 bit wide: reset, asynchronous, active-low.
REQ-005 The port start_i SHALL be an input, 1 bit wide: requests a pass; sampled only in S_IDLE.
REQ-006 The port abort_i SHALL be an input, 1 bit wide: terminates an active pass early.
REQ-007 The port base_addr_i SHALL be an input, ADDR_W bits wide: first address of the pass.
REQ-008 The port last_addr_i SHALL be an input, ADDR_W bits wide: final address of the pass.
REQ-009 The port we_mask_i SHALL be an input, 2 bits wide: per-RAM write enable mask (bit0 RAM0 sum, bit1 RAM1 difference).
REQ-010 The port read_address_o SHALL be an output, ADDR_W bits wide: address driven to port A of both RAMs.
REQ-011 The port write_address_o SHALL be an output, ADDR_W bits wide: address driven to port B of both RAMs.
REQ-012 The port write_enable_o SHALL be an output, 2 bits wide: port B write enables for RAM1:RAM0.
REQ-013 The port busy_o SHALL be an output, 1 bit wide: high while a pass is in progress.
REQ-014 The port done_o SHALL be an output, 1 bit wide: one-cycle pulse at pass end.
REQ-015 The port aborted_o SHALL be an output, 1 bit wide: qualifies done_o; high if the pass was aborted, held until the next start.
REQ-016 The port pass_count_o SHALL be an output, CNT_W bits wide: count of completed non-aborted passes.

Function
REQ-017 The FSM SHALL have exactly the states S_IDLE, S_READ_WRITE and S_LAST_WRITE, and all outputs SHALL be registered.
REQ-018 When start_i=1 in S_IDLE, the block SHALL, at that edge:
- latch last_addr_i and we_mask_i;
- load read_address_o <= base_addr_i;
- set busy_o <= 1 and aborted_o <= 0;
- enter S_READ_WRITE.
REQ-019 In S_READ_WRITE, every cycle the block SHALL:
- set read_address_o <= read_address_o+1, modulo 2^ADDR_W (511 wraps to 0);
- set write_address_o <= read_address_o;
- set write_enable_o <= latched mask.
REQ-020 Write enables SHALL therefore assert one cycle after each read address, matching the RAM's one-cycle read latency.
REQ-021 In S_READ_WRITE, when read_address_o equals the latched last address, the next state SHALL be S_LAST_WRITE.
REQ-022 In S_LAST_WRITE, the block SHALL:
- let the in-flight write complete;
- at the edge, clear write_enable_o, read_address_o and write_address_o to 0 and busy_o to 0;
- pulse done_o;
- return to S_IDLE.
REQ-023 done_o SHALL be high for exactly the first S_IDLE cycle after a pass.
REQ-024 A pass SHALL write exactly N = ((last-base) mod 2^ADDR_W)+1 consecutive addresses, beginning at base:
- last<base wraps through 511 to 0;
- last=base writes 1 word;
- last=base-1 writes all 512.
REQ-025 If abort_i=1 in S_READ_WRITE (including the cycle where the last-address compare is true), the next state SHALL be S_LAST_WRITE; the write already scheduled completes, no further reads are issued, and aborted_o <= 1.
REQ-026 abort_i SHALL be ignored in S_IDLE and S_LAST_WRITE.
REQ-027 start_i SHALL be ignored while busy_o=1, and SHALL be accepted in the S_IDLE cycle in which done_o is high.
REQ-028 pass_count_o SHALL increment by 1 at the end of each non-aborted pass, wrapping from 2^CNT_W-1 to 0.
REQ-029 we_mask_i=2'b00 SHALL still run a full-length pass with write_enable_o held at 0.
REQ-030 Inputs base_addr_i, last_addr_i and we_mask_i SHALL NOT affect an active pass after they are latched.

Reset
REQ-031 While resetn=0, the block SHALL asynchronously force state S_IDLE and all outputs to 0, and clear all latched values.
REQ-032 A reset asserted mid-pass SHALL deassert write_enable_o immediately, with no pulse on done_o.
REQ-033 After resetn rises, the block SHALL take no action until start_i is sampled high.

Verification
REQ-034 Full pass: base=0, last=511, mask=11, start pulse.
- write_enable_o=11 for 512 consecutive cycles, write addresses 0..511;
- done_o pulses once; pass_count_o=1; RAM0[i]=A+B and RAM1[i]=A-B (mod 256).
REQ-035 Wrap: base=510, last=1.
- write addresses 510, 511, 0, 1 (4 write cycles);
- read_address_o leads write_address_o by 1.
REQ-036 Single word: base=last=37, mask=01.
- exactly one cycle with write_enable_o=01 at address 37;
- done_o appears 3 cycles after the start edge.
REQ-037 Abort: base=0, last=100, abort_i pulsed at the 10th S_READ_WRITE cycle.
- writes 0..9 only; done_o=1 with aborted_o=1; pass_count_o unchanged.
REQ-038 Reset mid-pass at address 200.
- outputs 0 immediately; no done_o;
- a subsequent start with base=0, last=3 writes 0..3 normally.
REQ-039 Start ignored while busy: start_i held high throughout a base=0, last=5 pass.
- the second pass begins only in the done_o cycle;
- write_enable_o shows a 2-cycle gap between the passes.
